// File: rtl/instr_loader_pkg.sv
// instr_loader_pkg: sizing helpers and default-configuration constants shared by instr_loader.
package instr_loader_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int nbeats(input int instr_w, input int in_w);
        int n;
        n = (instr_w + in_w - 1) / in_w;
        return (n < 1) ? 1 : n;
    endfunction

    function automatic int beat_w(input int instr_w, input int in_w);
        int w;
        w = clog2(nbeats(instr_w, in_w));
        return (w < 1) ? 1 : w;
    endfunction

    localparam int NBEATS = nbeats(16, 8);
    localparam int BEAT_W = beat_w(16, 8);
    localparam int PTR_W  = clog2(4);
    localparam int CNT_W  = PTR_W + 1;

endpackage

// File: rtl/instr_loader_btn_conditioner.sv
// btn_conditioner: synchronises a raw button, debounces it and emits one pulse per accepted press.
module btn_conditioner
    import instr_loader_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_pulse
);
    localparam int CW = clog2(DEBOUNCE_CYC + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_db;
    logic                   r_db_prev;
    logic                   w_sync;

    assign w_sync  = r_sync[SYNC_STAGES-1];
    assign o_pulse = r_db & ~r_db_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync    <= '0;
            r_cnt     <= '0;
            r_db      <= 1'b0;
            r_db_prev <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], i_btn};
            r_db_prev <= r_db;
            if (w_sync == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYC - 1)) begin
                r_db  <= w_sync;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_loader.sv
// instr_loader: assembles multi-beat instructions from debounced button presses into an FWFT queue.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int IN_W         = 8,
    parameter int INSTR_W      = 16,
    parameter int DEPTH        = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [IN_W-1:0]                   data_in,
    input  logic                              btn_load,
    input  logic                              btn_abort,
    output logic [INSTR_W-1:0]                instr_out,
    output logic                              instr_valid,
    input  logic                              instr_ready,
    output logic [beat_w(INSTR_W, IN_W)-1:0]  beat_idx,
    output logic [clog2(DEPTH):0]             count,
    output logic                              full,
    output logic                              overflow,
    input  logic                              clr_overflow
);
    localparam int NB = nbeats(INSTR_W, IN_W);
    localparam int BW = beat_w(INSTR_W, IN_W);
    localparam int PW = clog2(DEPTH);

    logic               w_ld;
    logic               w_ab;
    logic               w_last;
    logic               w_push;
    logic               w_pop;
    logic               w_acc;
    logic [INSTR_W-1:0] w_asm_ld;
    logic [INSTR_W-1:0] r_asm;
    logic [INSTR_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]      r_wr;
    logic [PW-1:0]      r_rd;
    logic [PW:0]        r_cnt;
    logic [BW-1:0]      r_beat;
    logic               r_ovf;

    btn_conditioner #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYC(DEBOUNCE_CYC)) u_load (
        .clk(clk), .rst_n(rst_n), .i_btn(btn_load), .o_pulse(w_ld)
    );

    btn_conditioner #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYC(DEBOUNCE_CYC)) u_abort (
        .clk(clk), .rst_n(rst_n), .i_btn(btn_abort), .o_pulse(w_ab)
    );

    // Each assembly bit takes data_in only when its beat slot is the current one; the top slot truncates naturally.
    for (genvar i = 0; i < INSTR_W; i++) begin : g_asm
        assign w_asm_ld[i] = (r_beat == BW'(i / IN_W)) ? data_in[i % IN_W] : r_asm[i];
    end

    assign w_last      = (r_beat == BW'(NB - 1));
    assign w_push      = w_ld & ~w_ab & w_last;
    assign w_pop       = instr_valid & instr_ready;
    assign w_acc       = w_push & (~full | w_pop);
    assign instr_valid = (r_cnt != '0);
    assign full        = (r_cnt == (PW + 1)'(DEPTH));
    assign instr_out   = instr_valid ? r_mem[r_rd] : '0;
    assign beat_idx    = r_beat;
    assign count       = r_cnt;
    assign overflow    = r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_asm  <= '0;
            r_beat <= '0;
            r_wr   <= '0;
            r_rd   <= '0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
            for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
        end else begin
            if (w_ab) begin
                r_beat <= '0;
                r_asm  <= '0;
            end else if (w_ld) begin
                r_beat <= w_last ? '0 : r_beat + 1'b1;
                r_asm  <= w_last ? '0 : w_asm_ld;
            end
            if (w_acc) begin
                r_mem[r_wr] <= w_asm_ld;
                r_wr        <= r_wr + 1'b1;
            end
            if (w_pop) r_rd <= r_rd + 1'b1;
            if (w_acc & ~w_pop) r_cnt <= r_cnt + 1'b1;
            else if (w_pop & ~w_acc) r_cnt <= r_cnt - 1'b1;
            // A dropped word outranks a same-cycle clear.
            if (w_push & full & ~w_pop) r_ovf <= 1'b1;
            else if (clr_overflow) r_ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: three instr_loader configurations driven in parallel and checked against a queue-based model.
module tb_instr_loader;
    localparam int S = 2, D = 4, DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_in = '0;
    logic       btn_load = 1'b0, btn_abort = 1'b0, instr_ready = 1'b0, clr_overflow = 1'b0;

    logic [15:0] o0;
    logic [11:0] o1;
    logic [7:0]  o2;
    logic [2:0]  dv, dbeat, df, dov;
    logic [2:0]  dc0, dc1, dc2;
    logic [15:0] dout [3];
    logic [2:0]  dcnt [3];

    int total = 0, bad = 0;
    int iw [3] = '{16, 12, 8};
    int nb [3] = '{2, 2, 1};

    bit pp  [2][$];
    bit win [2][$];
    bit mdb [2];
    bit mdbp[2];
    int bq  [3][$];
    int mq  [3][$];
    bit mov [3];

    always #5 clk = ~clk;

    instr_loader #(.IN_W(8), .INSTR_W(16), .DEPTH(DEPTH), .SYNC_STAGES(S), .DEBOUNCE_CYC(D)) dut0 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .btn_load(btn_load), .btn_abort(btn_abort),
        .instr_out(o0), .instr_valid(dv[0]), .instr_ready(instr_ready), .beat_idx(dbeat[0:0]),
        .count(dc0), .full(df[0]), .overflow(dov[0]), .clr_overflow(clr_overflow));

    instr_loader #(.IN_W(8), .INSTR_W(12), .DEPTH(DEPTH), .SYNC_STAGES(S), .DEBOUNCE_CYC(D)) dut1 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .btn_load(btn_load), .btn_abort(btn_abort),
        .instr_out(o1), .instr_valid(dv[1]), .instr_ready(instr_ready), .beat_idx(dbeat[1:1]),
        .count(dc1), .full(df[1]), .overflow(dov[1]), .clr_overflow(clr_overflow));

    instr_loader #(.IN_W(8), .INSTR_W(8), .DEPTH(DEPTH), .SYNC_STAGES(S), .DEBOUNCE_CYC(D)) dut2 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .btn_load(btn_load), .btn_abort(btn_abort),
        .instr_out(o2), .instr_valid(dv[2]), .instr_ready(instr_ready), .beat_idx(dbeat[2:2]),
        .count(dc2), .full(df[2]), .overflow(dov[2]), .clr_overflow(clr_overflow));

    assign dout[0] = o0;
    assign dout[1] = {4'b0, o1};
    assign dout[2] = {8'b0, o2};
    assign dcnt[0] = dc0;
    assign dcnt[1] = dc1;
    assign dcnt[2] = dc2;

    task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] t=%0t got=%h want=%h", nm, c, $time, act, exp);
        end
    endtask

    function automatic void mreset();
        for (int b = 0; b < 2; b++) begin
            pp[b].delete();
            win[b].delete();
            for (int i = 0; i < S; i++) pp[b].push_back(1'b0);
            mdb[b]  = 1'b0;
            mdbp[b] = 1'b0;
        end
        for (int c = 0; c < 3; c++) begin
            bq[c].delete();
            mq[c].delete();
            mov[c] = 1'b0;
        end
    endfunction

    // Model: a press is accepted once the synchronised level has differed from the debounced level for D edges.
    function automatic void step();
        bit pl [2];
        bit pin[2];
        bit pop, push, flip;
        int n, w;
        pin[0] = btn_load;
        pin[1] = btn_abort;
        for (int b = 0; b < 2; b++) pl[b] = mdb[b] && !mdbp[b];
        for (int c = 0; c < 3; c++) begin
            n = mq[c].size();
            pop = (n > 0) && instr_ready;
            push = 1'b0;
            w = 0;
            if (pl[1]) bq[c].delete();
            else if (pl[0]) begin
                bq[c].push_back(int'(data_in));
                if (bq[c].size() == nb[c]) begin
                    for (int i = 0; i < nb[c]; i++) w = w | (bq[c][i] << (8 * i));
                    w = w & ((1 << iw[c]) - 1);
                    bq[c].delete();
                    push = 1'b1;
                end
            end
            if (pop) void'(mq[c].pop_front());
            if (push && (n < DEPTH || pop)) mq[c].push_back(w);
            if (push && n == DEPTH && !pop) mov[c] = 1'b1;
            else if (clr_overflow) mov[c] = 1'b0;
        end
        for (int b = 0; b < 2; b++) begin
            win[b].push_back(pp[b][0]);
            if (win[b].size() > D) void'(win[b].pop_front());
            flip = (win[b].size() == D);
            for (int i = 0; i < win[b].size(); i++) if (win[b][i] == mdb[b]) flip = 1'b0;
            mdbp[b] = mdb[b];
            if (flip) mdb[b] = !mdb[b];
            void'(pp[b].pop_front());
            pp[b].push_back(pin[b]);
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mreset();
        else step();
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int c = 0; c < 3; c++) begin
                chk("instr_out", c, 32'(dout[c]), (mq[c].size() > 0) ? mq[c][0] : 0);
                chk("instr_valid", c, 32'(dv[c]), 32'(mq[c].size() > 0));
                chk("beat_idx", c, 32'(dbeat[c]), bq[c].size());
                chk("count", c, 32'(dcnt[c]), mq[c].size());
                chk("full", c, 32'(df[c]), 32'(mq[c].size() == DEPTH));
                chk("overflow", c, 32'(dov[c]), 32'(mov[c]));
            end
        end
    end

    task automatic rst();
        @(negedge clk);
        #1 rst_n = 1'b0;
        btn_load = 1'b0;
        btn_abort = 1'b0;
        instr_ready = 1'b0;
        clr_overflow = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic press(input bit ld, input bit ab, input logic [7:0] d, input int hold,
                         input int rdy_at, input bit rnd = 1'b0);
        data_in = d;
        btn_load = ld;
        btn_abort = ab;
        for (int n = 1; n <= hold + 10; n++) begin
            @(negedge clk);
            if (n == hold) begin
                btn_load = 1'b0;
                btn_abort = 1'b0;
            end
            if (rnd) begin
                instr_ready = 1'($urandom_range(0, 1));
                clr_overflow = ($urandom_range(0, 7) == 0);
            end else if (rdy_at > 0) begin
                instr_ready = (n == rdy_at);
            end
        end
        instr_ready = 1'b0;
        clr_overflow = 1'b0;
    endtask

    initial begin
        int lat;
        rst();
        chk("reset_out", 0, 32'(o0), 0);
        chk("reset_valid", 0, 32'(dv), 0);

        // Two-beat assembly and push latency.
        press(1, 0, 8'h3A, 5, 0);
        chk("t1_beat1", 0, 32'(dbeat[0]), 1);
        data_in = 8'hC5;
        btn_load = 1'b1;
        lat = 0;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (n == 5) btn_load = 1'b0;
            if (lat == 0 && dv[0]) lat = n;
        end
        chk("t1_latency", 0, lat, 7);
        chk("t1_out", 0, 32'(o0), 32'h0000C53A);
        chk("t1_model", 0, mq[0][0], 32'h0000C53A);
        chk("t1_beat0", 0, 32'(dbeat[0]), 0);
        chk("t1_count", 0, 32'(dc0), 1);

        // Glitch shorter than the debounce window is ignored.
        rst();
        press(1, 0, 8'h10, 3, 0);
        chk("t2_glitch_beat", 0, 32'(dbeat[0]), 0);
        chk("t2_glitch_cnt8", 2, 32'(dc2), 0);
        press(1, 0, 8'h20, 4, 0);
        chk("t2_hold_beat", 0, 32'(dbeat[0]), 1);

        // Overflow, simultaneous pop+push on a full queue, clear.
        rst();
        for (int i = 0; i < 5; i++) begin
            press(1, 0, 8'(8'h10 + i), 5, 0);
            press(1, 0, 8'(8'hA0 + i), 5, 0);
        end
        chk("t3_count", 0, 32'(dc0), 4);
        chk("t3_full", 0, 32'(df[0]), 1);
        chk("t3_ovf", 0, 32'(dov[0]), 1);
        chk("t3_head", 0, 32'(o0), 32'h0000A010);
        press(1, 0, 8'h15, 5, 0);
        press(1, 0, 8'hA5, 5, 6);
        chk("t3_popush_count", 0, 32'(dc0), 4);
        chk("t3_popush_head", 0, 32'(o0), 32'h0000A111);
        chk("t3_popush_model", 0, mq[0][3], 32'h0000A515);
        @(negedge clk);
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        chk("t3_clr", 0, 32'(dov[0]), 0);

        // Abort discards a partial word; coincident abort and load discards the beat.
        rst();
        press(1, 0, 8'h77, 5, 0);
        press(0, 1, 8'h00, 5, 0);
        press(1, 0, 8'h11, 5, 0);
        press(1, 0, 8'h22, 5, 0);
        chk("t4_out", 0, 32'(o0), 32'h00002211);
        chk("t4_out12", 1, 32'(o1), 32'h00000211);
        press(1, 1, 8'h55, 5, 0);
        chk("t4_coinc_beat", 0, 32'(dbeat[0]), 0);
        chk("t4_coinc_count", 0, 32'(dc0), 1);
        chk("t4_coinc_cnt8", 2, 32'(dc2), 3);

        // Truncated top beat and single-beat words.
        rst();
        press(1, 0, 8'hA7, 5, 0);
        press(1, 0, 8'hF3, 5, 0);
        chk("t5_out12", 1, 32'(o1), 32'h000003A7);
        chk("t5_cnt8", 2, 32'(dc2), 2);
        chk("t5_out8", 2, 32'(o2), 32'h000000A7);

        // Asynchronous reset mid-cycle.
        rst();
        for (int i = 0; i < 5; i++) press(1, 0, 8'(i + 1), 5, 0);
        chk("t6_pre_beat", 0, 32'(dbeat[0]), 1);
        chk("t6_pre_count", 0, 32'(dc0), 2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_out", 0, 32'(o0), 0);
        chk("t6_async_valid", 0, 32'(dv), 0);
        chk("t6_async_beat", 0, 32'(dbeat), 0);
        chk("t6_async_count", 0, 32'(dc0), 0);
        chk("t6_async_full", 0, 32'(df), 0);
        chk("t6_async_ovf", 0, 32'(dov), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        press(1, 0, 8'h01, 5, 0);
        press(1, 0, 8'h02, 5, 0);
        chk("t6_after", 0, 32'(o0), 32'h00000201);

        // Randomised presses, aborts, glitches, ready and clear.
        rst();
        for (int k = 0; k < 80; k++) begin
            int r;
            r = $urandom_range(0, 19);
            press(r < 15 || r >= 18, r >= 15, 8'($urandom), $urandom_range(1, 7), 0, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
